mult_booth: RTL and testbench

- Sequential signed radix-2 Booth multiplier; the multiplicative counterpart of the CPU's sequential divider.
- Serves MULT in the same execute stage and writes the same hi/lo register pair.
- The control unit pulses multCtrl, then waits for done (or a fixed latency) before reading hi/lo.
- Uses the same start-pulse/hi-lo conventions as div, so the control FSM drives both blocks identically.

---
 rtl/mult_booth.sv | 134 +++++++++++++
 tb/tb_mult_booth.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier writing a hi/lo product pair; MULT_UNSIGNED_EN adds multU (MULTU support).
// Latency: n_bits cycles start edge to result edge (n_bits+1 with MULT_UNSIGNED_EN); done pulses for one cycle.
// Backpressure: none; multCtrl is honoured only in IDLE and ignored while busy or done.
module mult_booth #(
    parameter int n_bits = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n_bits-1:0] srcA,
    input  logic [n_bits-1:0] srcB,
    input  logic              multCtrl,
`ifdef MULT_UNSIGNED_EN
    input  logic              multU,
`endif
    output logic [n_bits-1:0] hi,
    output logic [n_bits-1:0] lo,
    output logic              busy,
    output logic              done
);

`ifdef MULT_UNSIGNED_EN
    localparam int QW = n_bits + 1;
`else
    localparam int QW = n_bits;
`endif
    // One guard bit on A keeps A-M exact even when M is the most-negative value.
    localparam int AW = QW + 1;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     a_reg;
    logic [QW-1:0]     m_reg;
    logic [QW-1:0]     q_reg;
    logic              q_m1;
    logic [CW-1:0]     count;

    logic [AW-1:0]     m_ext;
    logic [AW-1:0]     a_sum;
    logic [AW-1:0]     a_nxt;
    logic [QW-1:0]     q_nxt;
    logic [QW-1:0]     m_load;
    logic [QW-1:0]     q_load;
    logic [2*n_bits-1:0] prod_nxt;
    logic              start;
    logic              last_step;

`ifdef MULT_UNSIGNED_EN
    assign m_load = multU ? {1'b0, srcA} : {srcA[n_bits-1], srcA};
    assign q_load = multU ? {1'b0, srcB} : {srcB[n_bits-1], srcB};
`else
    assign m_load = srcA;
    assign q_load = srcB;
`endif

    always_comb begin
        m_ext = {m_reg[QW-1], m_reg};
        case ({q_reg[0], q_m1})
            2'b10:   a_sum = a_reg - m_ext;
            2'b01:   a_sum = a_reg + m_ext;
            default: a_sum = a_reg;
        endcase
        a_nxt    = {a_sum[AW-1], a_sum[AW-1:1]};
        q_nxt    = {a_sum[0], q_reg[QW-1:1]};
        prod_nxt = {a_nxt[2*n_bits-QW-1:0], q_nxt};
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (multCtrl) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            m_reg <= m_load;
            q_reg <= q_load;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= CW'(QW);
        end else if (state == RUN) begin
            a_reg <= a_nxt;
            q_reg <= q_nxt;
            q_m1  <= q_reg[0];
            count <= count - CW'(1);
            if (last_step) begin
                hi <= prod_nxt[2*n_bits-1:n_bits];
                lo <= prod_nxt[n_bits-1:0];
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_booth.sv
// Randomized scoreboard bench for mult_booth against a plain-arithmetic product model.
module tb_mult_booth;
    localparam int N = 32;
`ifdef MULT_UNSIGNED_EN
    localparam int LAT   = N + 1;
    localparam bit HAS_U = 1'b1;
`else
    localparam int LAT   = N;
    localparam bit HAS_U = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         multCtrl;
    logic         multU;
    logic [N-1:0] srcA;
    logic [N-1:0] srcB;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    mult_booth #(.n_bits(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .srcA     (srcA),
        .srcB     (srcB),
        .multCtrl (multCtrl),
`ifdef MULT_UNSIGNED_EN
        .multU    (multU),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc        = 0;
    int          free_cyc   = 0;
    int          rst_epoch  = 0;
    int          flush_upto = 0;
    int          rd_ptr     = 0;
    int          seen_epoch = 0;
    logic [63:0] last_prod  = '0;
    int          errors     = 0;
    int          checks     = 0;
    bit          end_req    = 1'b0;
    bit          end_seen   = 1'b0;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit uns);
        longint sa;
        longint sbv;
        if (uns) return {32'b0, a} * {32'b0, b};
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        return 64'(sa * sbv);
    endfunction

    // Model: one multiply in flight; a start is accepted once the unit is free again.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            rst_epoch  = rst_epoch + 1;
            flush_upto = sb.size();
            free_cyc   = cyc + 1;
        end else if (multCtrl && cyc >= free_cyc) begin
            sb.push_back('{ref_prod(srcA, srcB, HAS_U && multU), cyc + LAT});
            free_cyc = cyc + LAT + 2;
        end
    end

    always @(negedge clk) begin
        bit exp_done;
        bit exp_busy;
        if (rst_epoch > 0) begin
            if (rst_epoch != seen_epoch) begin
                seen_epoch = rst_epoch;
                rd_ptr     = flush_upto;
                last_prod  = '0;
            end
            exp_done = (rd_ptr < sb.size()) && (sb[rd_ptr].due == cyc);
            exp_busy = (rd_ptr < sb.size()) && (sb[rd_ptr].due > cyc);
            checks = checks + 1;
            if (done !== exp_done) begin
                errors = errors + 1;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
            end
            checks = checks + 1;
            if (busy !== exp_busy) begin
                errors = errors + 1;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            if (exp_done) begin
                last_prod = sb[rd_ptr].prod;
                rd_ptr    = rd_ptr + 1;
            end
            checks = checks + 1;
            if ({hi, lo} !== last_prod) begin
                errors = errors + 1;
                $display("FAIL hilo cyc=%0d got=%h_%h exp=%h", cyc, hi, lo, last_prod);
            end
            if (end_req && !end_seen) begin
                end_seen = 1'b1;
                checks   = checks + 1;
                if (rd_ptr != sb.size()) begin
                    errors = errors + 1;
                    $display("FAIL drained got=%0d exp=%0d results", rd_ptr, sb.size());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit u);
        srcA     = a;
        srcB     = b;
        multU    = u;
        multCtrl = 1'b1;
        tick(1);
        multCtrl = 1'b0;
        srcA     = $urandom;
        srcB     = $urandom;
        multU    = 1'($urandom % 2);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit u);
        start_op(a, b, u);
        tick(LAT + 3);
    endtask

    initial begin
        reset    = 1'b1;
        multCtrl = 1'b0;
        multU    = 1'b0;
        srcA     = '0;
        srcB     = '0;
        tick(2);
        reset = 1'b0;
        tick(1);

        run_op(32'hFFFF_FFE7, 32'd6, 1'b0);
        run_op(32'd1, 32'd1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd2, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Mid-run restart attempt, then reset abort, then a clean rerun.
        start_op(32'd3, 32'd5, 1'b0);
        tick(9);
        srcA     = 32'd7;
        srcB     = 32'd7;
        multCtrl = 1'b1;
        tick(1);
        multCtrl = 1'b0;
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        run_op(32'd3, 32'd5, 1'b0);

        // Back-to-back throughput with multCtrl held high.
        srcA     = 32'd2;
        srcB     = 32'd3;
        multU    = 1'b0;
        multCtrl = 1'b1;
        tick(34 * 3 + 2);
        multCtrl = 1'b0;
        tick(LAT + 4);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 25; i++) begin
            start_op(pick(), pick(), 1'($urandom % 2));
            for (int k = 0; k < LAT + 2; k++) begin
                multCtrl = ($urandom % 8) == 0;
                srcA     = pick();
                srcB     = pick();
                multU    = 1'($urandom % 2);
                tick(1);
            end
            multCtrl = 1'b0;
            tick(LAT + 4);
        end

        end_req = 1'b1;
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
